if_id_fetch_buffer: RTL and testbench
=====================================

Name: if_id_fetch_buffer

Overview:
Parametrised successor to the single-register IF/ID stage latch. It sits between instruction fetch and decode and holds up to DEPTH fetched {pc, inst} entries in a FIFO. Both sides use a valid/ready handshake, so decode can stall without losing fetched instructions. A synchronous flush discards every buffered entry on branch/jump redirect, and the block drives a NOP whenever it holds no valid entry.

Parameters:
XLEN, 32, width of pc and instruction words
DEPTH, 2, number of buffered entries (>=1; any integer, not only a power of 2)
NOP_INST, 32'h0000_0013, value driven on inst_out when the buffer is empty (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset (asserted when 0)
flush  in  1  synchronous flush; discards all entries at next posedge
in_valid  in  1  fetch presents a valid entry
in_ready  out  1  buffer can accept an entry this cycle
pc_in  in  XLEN  fetch pc
inst_in  in  XLEN  fetched instruction
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode consumes head this cycle
pc_out  out  XLEN  head pc
inst_out  out  XLEN  head instruction
occupancy  out  $clog2(DEPTH+1)  number of entries currently held

Behaviour:
- Reset (rst==0, asynchronous): count=0, rd_ptr=wr_ptr=0. Outputs: out_valid=0, in_ready=1, occupancy=0, pc_out=0, inst_out=NOP_INST. Storage array is not reset; outputs are masked while empty.
- Reset deassertion mid-transfer: any entry presented in the cycle of deassertion is accepted only at the first posedge with rst==1.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count < DEPTH); registered-state only, no combinational path from out_ready. When full, push cannot occur even if a pop happens in the same cycle. This costs one bubble when full and is accepted for timing.
- out_valid = (count != 0). When out_valid=1, pc_out/inst_out = storage[rd_ptr]. Otherwise pc_out=0 and inst_out=NOP_INST.
- Latency: an entry pushed at edge N is visible on outputs after edge N (out_valid high in cycle N+1). Empty-buffer throughput is 1 entry/cycle with simultaneous push/pop.
- Push writes storage[wr_ptr]. Pointers advance by 1 and wrap explicitly: ptr==DEPTH-1 -> 0. Do not rely on power-of-2 overflow.
- Count update: push&~pop -> +1; pop&~push -> -1; both or neither -> unchanged.
- Flush has priority over push and pop at the same edge. It sets count=0 and rd_ptr=wr_ptr=0, and the in-flight pc_in/inst_in is dropped. The cycle after flush has out_valid=0, inst_out=NOP_INST and in_ready=1.
- Flush while empty: no effect beyond pointer reset.
- occupancy = count.
- Assertions (verification only): count never exceeds DEPTH; no pop when count==0; no push when count==DEPTH.

Decomposition:
- Shared package fetch_pkg holds:
  - localparam NOP_INST_DEFAULT = 32'h0000_0013
  - typedef struct packed {logic [XLEN-1:0] pc; logic [XLEN-1:0] inst;} fetch_entry_t (XLEN fixed at 32 in the package)
- Storage, pointers and count are implemented inline in a single module; no sub-module required.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, inst_out=32'h13, pc_out=0, in_ready=1, occupancy=0. Release rst -> first posedge accepts pc_in.
- Streaming: DEPTH=2, out_ready=1, push pc 0x0,0x4,0x8 on consecutive cycles -> each appears one cycle later in order, occupancy stays at most 1, no drops.
- Fill/stall: out_ready=0, push 0x100,0x104 -> occupancy=2, in_ready=0. A third in_valid is not accepted. Raise out_ready -> drains 0x100 then 0x104, and in_ready returns 1 the cycle after the first pop.
- Flush priority: buffer holds 2 entries; assert flush with in_valid=1 and out_ready=1 in the same cycle -> next cycle occupancy=0, out_valid=0, inst_out=0x13, and the flushed-cycle input is never output.
- Wrap: DEPTH=3, random in_valid/out_ready for 1000 cycles against a scoreboard queue -> exact in-order match, pointers wrap 2->0, count never exceeds 3.
- Async reset mid-operation: with 2 entries held, drop rst between clock edges -> outputs go to reset values immediately without waiting for clk.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the IF/ID fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/if_id_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fetch_buffer
// Description : DEPTH-entry valid/ready FIFO between fetch and decode with
//               flush and NOP insertion while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_buffer
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEFAULT)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [XLEN-1:0]            pc_in,
   input  logic [XLEN-1:0]            inst_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            pc_out,
   output logic [XLEN-1:0]            inst_out,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int                 PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                 CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]   C_LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]   C_DEPTH    = CNT_W'(DEPTH);

   logic [XLEN-1:0]  pc_mem_q   [DEPTH];
   logic [XLEN-1:0]  inst_mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             push, pop;

   // in_ready depends on registered count only, so a full buffer takes one bubble
   assign in_ready  = (count_q < C_DEPTH);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign occupancy = count_q;
   assign pc_out    = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
   assign inst_out  = out_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; outputs are masked while empty
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= pc_in;
         inst_mem_q[wr_ptr_q] <= inst_in;
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (!rst) count_q <= C_DEPTH);
   a_no_underflow : assert property (@(posedge clk) disable iff (!rst) !(pop && count_q == '0));
   a_no_overflow  : assert property (@(posedge clk) disable iff (!rst) !(push && count_q == C_DEPTH));

endmodule : if_id_fetch_buffer
`default_nettype wire

// File: tb/tb_if_id_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_fetch_buffer
// Description : Directed self-checking bench for if_id_fetch_buffer (DEPTH 2 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_buffer;
   import fetch_pkg::*;

   logic        clk;
   logic        rst;
   int          checks;
   int          errors;

   logic        d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
   logic [31:0] d2_pc_in, d2_inst_in, d2_pc_out, d2_inst_out;
   logic [1:0]  d2_occ;

   logic        d3_flush, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
   logic [31:0] d3_pc_in, d3_inst_in, d3_pc_out, d3_inst_out;
   logic [1:0]  d3_occ;

   if_id_fetch_buffer #(.XLEN(32), .DEPTH(2), .NOP_INST(32'h0000_0013)) u_dut2 (
      .clk(clk), .rst(rst), .flush(d2_flush),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .pc_in(d2_pc_in), .inst_in(d2_inst_in),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready),
      .pc_out(d2_pc_out), .inst_out(d2_inst_out), .occupancy(d2_occ)
   );

   if_id_fetch_buffer #(.XLEN(32), .DEPTH(3), .NOP_INST(32'h0000_0013)) u_dut3 (
      .clk(clk), .rst(rst), .flush(d3_flush),
      .in_valid(d3_in_valid), .in_ready(d3_in_ready),
      .pc_in(d3_pc_in), .inst_in(d3_inst_in),
      .out_valid(d3_out_valid), .out_ready(d3_out_ready),
      .pc_out(d3_pc_out), .inst_out(d3_inst_out), .occupancy(d3_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      d2_in_valid = 1'b1; d2_pc_in = 32'h40; d2_inst_in = 32'hAA;
      repeat (3) step();
      checks++; if (d2_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", d2_out_valid); end
      checks++; if (d2_inst_out !== 32'h13) begin errors++; $display("FAIL reset_inst_out got %h exp 00000013", d2_inst_out); end
      checks++; if (d2_pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h exp 00000000", d2_pc_out); end
      checks++; if (d2_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", d2_in_ready); end
      checks++; if (d2_occ !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", d2_occ); end
      rst = 1'b1;
      step();
      checks++; if (d2_occ !== 2'd1) begin errors++; $display("FAIL reset_release_occ got %0d exp 1", d2_occ); end
      checks++; if (d2_pc_out !== 32'h40 || d2_inst_out !== 32'hAA) begin errors++; $display("FAIL reset_release_head got %h/%h exp 00000040/000000aa", d2_pc_out, d2_inst_out); end
      d2_in_valid = 1'b0; d2_out_ready = 1'b1;
      step();
      checks++; if (d2_occ !== 2'd0 || d2_out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain got occ %0d valid %b exp 0 0", d2_occ, d2_out_valid); end
   endtask

   task automatic test_streaming();
      logic [31:0] pcs [3];
      pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
      d2_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d2_in_valid = 1'b1; d2_pc_in = pcs[i]; d2_inst_in = 32'h1000 + 32'(i);
         step();
         checks++;
         if (d2_out_valid !== 1'b1 || d2_pc_out !== pcs[i] || d2_inst_out !== 32'h1000 + 32'(i) || d2_occ !== 2'd1) begin
            errors++;
            $display("FAIL stream_%0d got v%b pc %h inst %h occ %0d exp v1 pc %h inst %h occ 1",
                     i, d2_out_valid, d2_pc_out, d2_inst_out, d2_occ, pcs[i], 32'h1000 + 32'(i));
         end
      end
      d2_in_valid = 1'b0;
      step();
      checks++; if (d2_occ !== 2'd0 || d2_inst_out !== 32'h13) begin errors++; $display("FAIL stream_end got occ %0d inst %h exp 0 00000013", d2_occ, d2_inst_out); end
   endtask

   task automatic test_fill_stall();
      d2_out_ready = 1'b0;
      d2_in_valid = 1'b1; d2_pc_in = 32'h100; d2_inst_in = 32'hA100;
      step();
      d2_pc_in = 32'h104; d2_inst_in = 32'hA104;
      step();
      checks++; if (d2_occ !== 2'd2) begin errors++; $display("FAIL fill_occ got %0d exp 2", d2_occ); end
      checks++; if (d2_in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", d2_in_ready); end
      d2_pc_in = 32'h108; d2_inst_in = 32'hA108;
      step();
      checks++; if (d2_occ !== 2'd2 || d2_pc_out !== 32'h100) begin errors++; $display("FAIL fill_third_rejected got occ %0d pc %h exp 2 00000100", d2_occ, d2_pc_out); end
      d2_in_valid = 1'b0; d2_out_ready = 1'b1;
      step();
      checks++; if (d2_pc_out !== 32'h104 || d2_inst_out !== 32'hA104 || d2_occ !== 2'd1) begin errors++; $display("FAIL drain_second got pc %h inst %h occ %0d exp 00000104 0000a104 1", d2_pc_out, d2_inst_out, d2_occ); end
      checks++; if (d2_in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready got %b exp 1", d2_in_ready); end
      step();
      checks++; if (d2_out_valid !== 1'b0 || d2_inst_out !== 32'h13) begin errors++; $display("FAIL drain_empty got v%b inst %h exp v0 00000013", d2_out_valid, d2_inst_out); end
   endtask

   task automatic test_flush();
      d2_out_ready = 1'b0;
      d2_in_valid = 1'b1; d2_pc_in = 32'h200; d2_inst_in = 32'hB200;
      step();
      d2_pc_in = 32'h204; d2_inst_in = 32'hB204;
      step();
      checks++; if (d2_occ !== 2'd2) begin errors++; $display("FAIL flush_prefill got %0d exp 2", d2_occ); end
      d2_flush = 1'b1; d2_out_ready = 1'b1; d2_pc_in = 32'h300; d2_inst_in = 32'hC300;
      step();
      checks++;
      if (d2_occ !== 2'd0 || d2_out_valid !== 1'b0 || d2_inst_out !== 32'h13 || d2_pc_out !== 32'h0 || d2_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_after got occ %0d v%b inst %h pc %h rdy %b exp 0 v0 00000013 00000000 1",
                  d2_occ, d2_out_valid, d2_inst_out, d2_pc_out, d2_in_ready);
      end
      d2_flush = 1'b0; d2_in_valid = 1'b0;
      step();
      checks++; if (d2_out_valid !== 1'b0 || d2_pc_out === 32'h300) begin errors++; $display("FAIL flush_dropped got v%b pc %h exp v0", d2_out_valid, d2_pc_out); end
      // pointers back at zero: a fresh push must appear at the head
      d2_in_valid = 1'b1; d2_pc_in = 32'h400; d2_inst_in = 32'hD400; d2_out_ready = 1'b0;
      step();
      d2_in_valid = 1'b0;
      checks++; if (d2_pc_out !== 32'h400 || d2_occ !== 2'd1) begin errors++; $display("FAIL flush_repush got pc %h occ %0d exp 00000400 1", d2_pc_out, d2_occ); end
      d2_out_ready = 1'b1;
      step();
   endtask

   task automatic test_async_reset();
      d2_out_ready = 1'b0;
      d2_in_valid = 1'b1; d2_pc_in = 32'h500; d2_inst_in = 32'hE500;
      step();
      d2_pc_in = 32'h504; d2_inst_in = 32'hE504;
      step();
      d2_in_valid = 1'b0;
      checks++; if (d2_occ !== 2'd2) begin errors++; $display("FAIL async_prefill got %0d exp 2", d2_occ); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (d2_occ !== 2'd0 || d2_out_valid !== 1'b0 || d2_inst_out !== 32'h13 || d2_pc_out !== 32'h0 || d2_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset got occ %0d v%b inst %h pc %h rdy %b exp 0 v0 00000013 00000000 1",
                  d2_occ, d2_out_valid, d2_inst_out, d2_pc_out, d2_in_ready);
      end
      #1 rst = 1'b1;
      step();
   endtask

   task automatic test_wrap();
      fetch_entry_t sb [$];
      fetch_entry_t e;
      logic         pu, po;
      int           seq;
      int           bad;
      seq = 0;
      bad = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         checks++;
         if (d3_occ !== 2'(sb.size()) || d3_out_valid !== (sb.size() != 0) || d3_in_ready !== (sb.size() < 3) ||
             (sb.size() != 0 && (d3_pc_out !== sb[0].pc || d3_inst_out !== sb[0].inst)) ||
             (sb.size() == 0 && (d3_pc_out !== 32'h0 || d3_inst_out !== 32'h13))) begin
            errors++;
            bad++;
            if (bad <= 20)
               $display("FAIL wrap_cycle_%0d got occ %0d v%b pc %h inst %h exp occ %0d head pc %h",
                        cyc, d3_occ, d3_out_valid, d3_pc_out, d3_inst_out, sb.size(),
                        (sb.size() != 0) ? sb[0].pc : 32'h0);
         end
         d3_in_valid  = ($urandom_range(0, 3) != 0);
         d3_out_ready = ($urandom_range(0, 2) != 0);
         d3_flush     = ($urandom_range(0, 63) == 0);
         d3_pc_in     = 32'(seq) << 2;
         d3_inst_in   = $urandom;
         pu = d3_in_valid && (sb.size() < 3) && !d3_flush;
         po = d3_out_ready && (sb.size() != 0) && !d3_flush;
         step();
         if (d3_flush) sb.delete();
         if (po) void'(sb.pop_front());
         if (pu) begin
            e.pc = d3_pc_in; e.inst = d3_inst_in;
            sb.push_back(e);
            seq++;
         end
      end
      d3_in_valid = 1'b0; d3_flush = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0;
      d2_flush = 1'b0; d2_in_valid = 1'b0; d2_out_ready = 1'b0; d2_pc_in = '0; d2_inst_in = '0;
      d3_flush = 1'b0; d3_in_valid = 1'b0; d3_out_ready = 1'b0; d3_pc_in = '0; d3_inst_in = '0;
      test_reset();
      test_streaming();
      test_fill_stall();
      test_flush();
      test_async_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_if_id_fetch_buffer
`default_nettype wire
